// File: rtl/mygo_chan_send_arb.sv
// Round-robin arbiter that merges NUM_SENDERS producer handshakes onto one
// channel FIFO write port through a one-entry registered output stage.
module mygo_chan_send_arb #(
  parameter int NUM_SENDERS = 4,
  parameter int WIDTH       = 32,
  parameter int SEL_BITS    = (NUM_SENDERS <= 1) ? 1 : $clog2(NUM_SENDERS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SENDERS*WIDTH-1:0] req_data,
  input  logic [NUM_SENDERS-1:0]       req_valid,
  output logic [NUM_SENDERS-1:0]       req_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SEL_BITS-1:0]          out_src,
  output logic [SEL_BITS-1:0]          rr_ptr
);

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_BITS-1:0] out_src_q, out_src_d;
  logic [SEL_BITS-1:0] rr_ptr_q, rr_ptr_d;

  logic                slot_free;
  logic                any_req;
  logic                xfer;
  logic                hi_found, lo_found;
  logic [SEL_BITS-1:0] hi_idx, lo_idx;
  logic [SEL_BITS-1:0] win_idx;
  logic [SEL_BITS-1:0] ptr_next;
  logic [WIDTH-1:0]    win_data;

  assign slot_free = !out_valid_q || out_ready;

  // Scanning downward leaves the lowest valid index at or above rr_ptr in
  // hi_idx and the lowest below it in lo_idx; hi wins, lo covers the wrap.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_SENDERS - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (SEL_BITS'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = SEL_BITS'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = SEL_BITS'(i);
        end
      end
    end
  end

  assign any_req = hi_found || lo_found;
  assign win_idx = hi_found ? hi_idx : lo_idx;
  assign xfer    = any_req && slot_free && !rst;

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_SENDERS; i++) begin
      if (win_idx == SEL_BITS'(i)) begin
        win_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Wrap at NUM_SENDERS so non-power-of-two counts never reach unused indices.
  always_comb begin
    if (win_idx == SEL_BITS'(NUM_SENDERS - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = win_idx + SEL_BITS'(1);
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_SENDERS; i++) begin
      if (xfer && (win_idx == SEL_BITS'(i))) begin
        req_ready[i] = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data;
      out_src_d   = win_idx;
      rr_ptr_d    = ptr_next;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign rr_ptr    = rr_ptr_q;

endmodule
